// File: rtl/decode_issue_queue_pkg.sv
// rtl/decode_issue_queue_pkg.sv - shared decode constants, issue-entry struct and helpers
// Purpose: opcode/funct constants, ALU/FU/operand/immediate selector enums,
//          the decoded issue-queue entry type and immediate/ALU helpers.
// Ports:   none (package).
package decode_issue_queue_pkg;

  localparam int XLEN      = 32;
  localparam int TID_WIDTH = 2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_BEQ     = 3'b000;
  localparam logic [2:0] FUNCT3_BNE     = 3'b001;
  localparam logic [2:0] FUNCT3_BLT     = 3'b100;
  localparam logic [2:0] FUNCT3_BGE     = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU    = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU    = 3'b111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR,
    ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
    ALU_OP_SEQ, ALU_OP_SNE, ALU_OP_SGE, ALU_OP_SGEU,
    ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
    ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU
  } alu_op_e;

  typedef enum logic [2:0] {
    FU_SEL_NONE, FU_SEL_RS, FU_SEL_BRANCH, FU_SEL_LSU, FU_SEL_MUL
  } fu_sel_e;

  typedef enum logic [1:0] {
    OP_SEL_RS1_RS2, OP_SEL_RS1_IMM, OP_SEL_PC_IMM, OP_SEL_ZERO_IMM
  } op_sel_e;

  typedef enum logic [2:0] {
    IMM_SEL_NONE, IMM_SEL_I, IMM_SEL_S, IMM_SEL_B, IMM_SEL_U, IMM_SEL_J
  } imm_sel_e;

  typedef struct packed {
    logic                 illegal;
    fu_sel_e              fu_sel;
    op_sel_e              op_sel;
    alu_op_e              alu_op;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [TID_WIDTH-1:0] thread_id;
  } decode_issue_struct_o;

  // Shared integer-op mapping; alt selects SUB/SRA where funct3 allows it.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      FUNCT3_ADD_SUB: alu_from_funct3 = alt ? ALU_OP_SUB : ALU_OP_ADD;
      FUNCT3_SLL:     alu_from_funct3 = ALU_OP_SLL;
      FUNCT3_SLT:     alu_from_funct3 = ALU_OP_SLT;
      FUNCT3_SLTU:    alu_from_funct3 = ALU_OP_SLTU;
      FUNCT3_XOR:     alu_from_funct3 = ALU_OP_XOR;
      FUNCT3_SRL_SRA: alu_from_funct3 = alt ? ALU_OP_SRA : ALU_OP_SRL;
      FUNCT3_OR:      alu_from_funct3 = ALU_OP_OR;
      default:        alu_from_funct3 = ALU_OP_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] instr, input imm_sel_e sel);
    case (sel)
      IMM_SEL_I: gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_SEL_S: gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_SEL_B: gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_SEL_U: gen_imm = {instr[31:12], 12'h000};
      IMM_SEL_J: gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:   gen_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_queue_decode_lane.sv
// rtl/decode_issue_queue_decode_lane.sv - combinational single-instruction decoder
// Purpose: decodes one instruction into a decode_issue_struct_o entry.
// Config:  DECODE_ISSUE_M_EXT_EN enables OP_R funct7=0000001 (MUL/DIV) decode.
// Ports:   i_instr  - instruction word
//          i_pc     - instruction PC
//          i_thread - thread id
//          o_dec    - decoded entry
module decode_lane
  import decode_issue_queue_pkg::*;
(
  input  logic [XLEN-1:0]      i_instr,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [TID_WIDTH-1:0] i_thread,
  output decode_issue_struct_o o_dec
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  imm_sel_e   w_imm_sel;
  fu_sel_e    w_fu_sel;
  op_sel_e    w_op_sel;
  alu_op_e    w_alu_op;
  logic       w_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  always_comb begin
    w_imm_sel = IMM_SEL_NONE;
    w_fu_sel  = FU_SEL_NONE;
    w_op_sel  = OP_SEL_RS1_RS2;
    w_alu_op  = ALU_OP_ADD;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_LUI:   begin w_fu_sel = FU_SEL_RS;     w_op_sel = OP_SEL_ZERO_IMM; w_imm_sel = IMM_SEL_U; end
      OP_AUIPC: begin w_fu_sel = FU_SEL_RS;     w_op_sel = OP_SEL_PC_IMM;   w_imm_sel = IMM_SEL_U; end
      OP_JAL:   begin w_fu_sel = FU_SEL_BRANCH; w_op_sel = OP_SEL_PC_IMM;   w_imm_sel = IMM_SEL_J; end
      OP_JALR:  begin w_fu_sel = FU_SEL_BRANCH; w_op_sel = OP_SEL_RS1_IMM;  w_imm_sel = IMM_SEL_I; end
      OP_LOAD:  begin w_fu_sel = FU_SEL_LSU;    w_op_sel = OP_SEL_RS1_IMM;  w_imm_sel = IMM_SEL_I; end
      OP_STORE: begin w_fu_sel = FU_SEL_LSU;    w_op_sel = OP_SEL_RS1_IMM;  w_imm_sel = IMM_SEL_S; end
      OP_BRANCH: begin
        w_fu_sel  = FU_SEL_BRANCH;
        w_imm_sel = IMM_SEL_B;
        case (w_funct3)
          FUNCT3_BEQ:  w_alu_op = ALU_OP_SEQ;
          FUNCT3_BNE:  w_alu_op = ALU_OP_SNE;
          FUNCT3_BLT:  w_alu_op = ALU_OP_SLT;
          FUNCT3_BGE:  w_alu_op = ALU_OP_SGE;
          FUNCT3_BLTU: w_alu_op = ALU_OP_SLTU;
          FUNCT3_BGEU: w_alu_op = ALU_OP_SGEU;
          default:     w_illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        w_fu_sel  = FU_SEL_RS;
        w_op_sel  = OP_SEL_RS1_IMM;
        w_imm_sel = IMM_SEL_I;
        // instr[30] is immediate data for addi, so only the shift form may use it.
        w_alu_op  = alu_from_funct3(w_funct3, (w_funct3 == FUNCT3_SRL_SRA) && i_instr[30]);
      end
      OP_R: begin
        w_fu_sel = FU_SEL_RS;
        case (w_funct7)
          FUNCT7_BASE: w_alu_op = alu_from_funct3(w_funct3, 1'b0);
          FUNCT7_ALT:  w_alu_op = alu_from_funct3(w_funct3, 1'b1);
`ifdef DECODE_ISSUE_M_EXT_EN
          FUNCT7_MULDIV: begin
            w_fu_sel = FU_SEL_MUL;
            case (w_funct3)
              3'b000:  w_alu_op = ALU_OP_MUL;
              3'b001:  w_alu_op = ALU_OP_MULH;
              3'b010:  w_alu_op = ALU_OP_MULHSU;
              3'b011:  w_alu_op = ALU_OP_MULHU;
              3'b100:  w_alu_op = ALU_OP_DIV;
              3'b101:  w_alu_op = ALU_OP_DIVU;
              3'b110:  w_alu_op = ALU_OP_REM;
              default: w_alu_op = ALU_OP_REMU;
            endcase
          end
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal entries still enqueue in order; neutralise their execution fields.
    if (w_illegal) begin
      w_fu_sel  = FU_SEL_NONE;
      w_op_sel  = OP_SEL_RS1_RS2;
      w_alu_op  = ALU_OP_ADD;
      w_imm_sel = IMM_SEL_NONE;
    end
  end

  always_comb begin
    o_dec           = '0;
    o_dec.illegal   = w_illegal;
    o_dec.fu_sel    = w_fu_sel;
    o_dec.op_sel    = w_op_sel;
    o_dec.alu_op    = w_alu_op;
    o_dec.rd        = i_instr[11:7];
    o_dec.rs1       = i_instr[19:15];
    o_dec.rs2       = i_instr[24:20];
    o_dec.imm       = gen_imm(i_instr, w_imm_sel);
    o_dec.pc        = i_pc;
    o_dec.thread_id = i_thread;
  end

endmodule

// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - N-wide decoder feeding an in-order circular issue queue
// Purpose: decodes up to ISSUE_WIDTH instructions per cycle and queues them;
//          drains up to ISSUE_WIDTH oldest entries per cycle.
// Config:  DECODE_ISSUE_M_EXT_EN (see decode_lane) enables M-extension decode.
// Ports:   clk, rst (async active-high), flush_i - clear queue and drop input
//          in_valid_i/in_instr_i/in_pc_i/in_thread_i/in_ready_o - input group
//          issue_valid_o/issue_o/issue_ready_i - prefix issue handshake, lane 0 oldest
//          count_o - occupancy
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush_i,
  input  logic [ISSUE_WIDTH-1:0]                    in_valid_i,
  input  logic [ISSUE_WIDTH*XLEN-1:0]               in_instr_i,
  input  logic [ISSUE_WIDTH*XLEN-1:0]               in_pc_i,
  input  logic [TID_WIDTH-1:0]                      in_thread_i,
  output logic                                      in_ready_o,
  output logic [ISSUE_WIDTH-1:0]                    issue_valid_o,
  output decode_issue_struct_o [ISSUE_WIDTH-1:0]    issue_o,
  input  logic [ISSUE_WIDTH-1:0]                    issue_ready_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]          count_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

  decode_issue_struct_o r_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  decode_issue_struct_o   w_dec    [ISSUE_WIDTH];
  logic [PTR_W-1:0]       w_rd_idx [ISSUE_WIDTH];
  logic [PTR_W-1:0]       w_wr_idx [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] w_enq;
  logic [ISSUE_WIDTH-1:0] w_deq;
  logic [CNT_W-1:0]       w_enq_n;
  logic [CNT_W-1:0]       w_deq_n;
  logic [ISSUE_WIDTH-1:0] w_rdy_inc;
  logic [ISSUE_WIDTH-1:0] w_vld_inc;

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
    decode_lane u_decode_lane (
      .i_instr  (in_instr_i[k*XLEN +: XLEN]),
      .i_pc     (in_pc_i[k*XLEN +: XLEN]),
      .i_thread (in_thread_i),
      .o_dec    (w_dec[k])
    );
    // Pointers are exactly log2(depth) bits so these sums wrap around the ring.
    assign w_rd_idx[k] = r_head + PTR_W'(k);
    assign w_wr_idx[k] = r_tail + PTR_W'(k);
  end

  assign count_o = r_count;
  // Only the current count is considered; a same-cycle dequeue frees nothing yet.
  assign in_ready_o = (CNT_W'(QUEUE_DEPTH) - r_count) >= CNT_W'(ISSUE_WIDTH);

  always_comb begin
    issue_valid_o = '0;
    issue_o       = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      issue_valid_o[k] = (r_count > CNT_W'(k)) && r_vld[w_rd_idx[k]];
      issue_o[k]       = r_mem[w_rd_idx[k]];
    end
  end

  always_comb begin
    w_enq   = flush_i ? '0 : (in_valid_i & {ISSUE_WIDTH{in_ready_o}});
    w_deq   = flush_i ? '0 : (issue_valid_o & issue_ready_i);
    w_enq_n = '0;
    w_deq_n = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_enq_n = w_enq_n + CNT_W'(w_enq[k]);
      w_deq_n = w_deq_n + CNT_W'(w_deq[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      // Enqueue only targets free slots, so these never touch the same bit.
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (w_deq[k]) r_vld[w_rd_idx[k]] <= 1'b0;
        if (w_enq[k]) r_vld[w_wr_idx[k]] <= 1'b1;
      end
      r_head  <= r_head + PTR_W'(w_deq_n);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Payload needs no reset; r_vld and r_count guard every read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (w_enq[k]) r_mem[w_wr_idx[k]] <= w_dec[k];
    end
  end

  // A prefix mask plus one clears all of its set bits.
  assign w_rdy_inc = issue_ready_i + ISSUE_WIDTH'(1);
  assign w_vld_inc = in_valid_i + ISSUE_WIDTH'(1);

  a_issue_ready_prefix: assert property (@(posedge clk) disable iff (rst)
    (issue_ready_i & w_rdy_inc) == '0);
  a_in_valid_prefix: assert property (@(posedge clk) disable iff (rst)
    (in_valid_i & w_vld_inc) == '0);
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    r_count <= CNT_W'(QUEUE_DEPTH));

endmodule
